estacao_reserva_ua: RTL and testbench
=====================================

Name: estacao_reserva_ua

Overview:
- Reservation station and dispatch controller that drives the 3-cycle arithmetic/address unit (UA) from the issuing side of its start/busy/confirmacao handshake.
- Holds up to N issued instructions and snoops the common data bus (CDB) for missing operands.
- Dispatches ready entries to the UA one at a time, captures each result and broadcasts it on the CDB tagged with the entry ID.
- Sits between the issue stage and the UA, one instance per UA.

Parameters:
N_ENTRADAS, 3, number of entries; entry k has ID ID_BASE+k
ID_BASE, 1, ID of entry 0; tag 0 means "no dependency"
DATA_W, 16, operand/result width
TAG_W, 3, tag/ID width; ID_BASE+N_ENTRADAS-1 must fit

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  synchronous active-high reset
issue_valid  in  1  issue request
issue_op  in  3  001 add, 010 sub, 011 load addr, 100 store addr
issue_vj, issue_vk  in  DATA_W  operand values
issue_qj, issue_qk  in  TAG_W  producer tags, 0 = value valid
issue_ready  out  1  at least one free entry
issue_id  out  TAG_W  ID allocated if issue accepted this cycle
cdb_valid  in  1  global CDB valid
cdb_tag  in  TAG_W  global CDB tag
cdb_data  in  DATA_W  global CDB data
ua_start  out  1  one-cycle start pulse to UA
ua_id  out  TAG_W  ID of the dispatched entry
ua_op  out  3  operation
ua_dado1, ua_dado2  out  DATA_W  operands Vj, Vk
ua_busy  in  1  UA busy
ua_confirmacao  in  1  UA result valid; level signal, cleared by the next accepted start
ua_resultado  in  19  UA result; only bits 15:0 used
bc_req  out  1  CDB broadcast request
bc_tag  out  TAG_W  broadcast tag (entry ID)
bc_data  out  DATA_W  broadcast data
bc_grant  in  1  CDB arbiter grant; broadcast completes this cycle

Behaviour:
- Reset (CLR at edge): all entries invalid; FSM to IDLE. ua_start, bc_req, ua_op, ua_id, ua_dado1/2, bc_tag, bc_data = 0. issue_ready = 1 on the following cycle. CLR mid-dispatch abandons the in-flight op; the UA shares CLR.
- Entry fields: valid, op, Vj, Qj, Vk, Qk, inflight.
- Entry ready when valid, Qj = 0, Qk = 0 and not inflight.

Issue:
- Accepted when issue_valid, issue_ready and issue_op is in 001..100.
- Allocates the lowest-index free entry. issue_id is combinational from the free-entry priority encoder.
- issue_op outside 001..100 is dropped: no allocation, no state change.
- Same-cycle bypass: if cdb_valid and cdb_tag equals issue_qj (nonzero), store cdb_data as Vj with Qj = 0. Same rule for Qk.

Snoop:
- Every cycle, each valid entry with Qj = cdb_tag (nonzero) while cdb_valid captures cdb_data and clears Qj. Same for Qk.
- Both operands may match the same broadcast in one cycle.

Dispatch FSM:
- IDLE: if any entry is ready and ua_busy = 0, select the lowest-index ready entry, register op/Vj/Vk/ID onto the ua_* outputs, set its inflight bit, go to START.
- START: ua_start = 1 for exactly one cycle, then go to WAIT.
- WAIT: ua_start = 0. On the cycle where ua_confirmacao = 1 and ua_busy = 0, latch ua_resultado[15:0] into bc_data and the inflight ID into bc_tag, go to BCAST.
  - WAIT is entered after the UA has already cleared the stale confirmacao.
  - Start is sampled at edge E; the result is valid after edge E+2 and captured at edge E+3.
- BCAST: bc_req = 1 with bc_tag/bc_data stable until bc_grant. On the grant cycle: free the entry (valid = 0, inflight = 0), drop bc_req, go to IDLE.
- Own broadcasts return on cdb_*; dependent entries capture them by the normal snoop rule.

Latency and boundaries:
- Best-case latency from ready to bc_req is 5 cycles; one op is in flight at a time.
- Full: issue_ready = 0. An entry freed on a grant cycle becomes available on the next cycle; no same-cycle reuse.
- Tag values outside the entry IDs are ignored by allocation logic but still matched by snoop.

Decomposition:
- Shared package (tomasulo_pkg): op codes OP_ADD = 001, OP_SUB = 010, OP_LD = 011, OP_ST = 100; TAG_NONE = 0; TAG_W; DATA_W; FSM state encoding IDLE/START/WAIT/BCAST.
- Sub-module estacao_entrada: one entry with register fields, issue-write port and CDB snoop compare; instantiated N_ENTRADAS times.
- Top level holds the priority encoders, FSM and output registers.

Test Plan:
- Reset, then issue add Vj = 5, Vk = 7, Qj = Qk = 0 -> issue_id = 1; ua_start pulses once; 3 cycles later bc_req = 1, bc_tag = 1, bc_data = 12; grant frees entry 1.
- Issue sub with Qj = 5; cdb tag 5 data 20 two cycles later; Vk = 3 -> no ua_start before the CDB hit; then dispatch, bc_data = 17.
- Issue with qk = 4 while cdb_valid with tag 4 data 9 in the same cycle -> entry captures 9 immediately and dispatches without waiting.
- Fill 3 entries all waiting on tag 6 -> issue_ready = 0 and a 4th issue is ignored; after tag 6 broadcast, entries dispatch in order 1, 2, 3; each bc_req is held 4 cycles without grant and data stays stable.
- Chain: entry 2 depends on entry 1 (qj = 1); entry 1 computes 3+4 -> on entry 1 grant, entry 2 captures 7 via snoop and then dispatches.
- CLR asserted during WAIT -> next cycle ua_start = 0, bc_req = 0, issue_ready = 1; the next issue gets issue_id = 1.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared constants for the UA reservation station: op codes, tag
// conventions, default widths and the dispatch FSM encoding.
package tomasulo_pkg;

  localparam int DATA_W   = 16;
  localparam int TAG_W    = 3;
  localparam int TAG_NONE = 0;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_BCAST = 2'd3;

  // Only add/sub/load-addr/store-addr are executed by the UA.
  function automatic logic op_suportado(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_ST);
  endfunction

endpackage

// File: rtl/estacao_entrada.sv
// One reservation-station entry: operand/tag storage, issue write port
// with same-cycle CDB bypass, and continuous CDB snoop.
module estacao_entrada
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              wr_i,
  input  logic [2:0]        wr_op_i,
  input  logic [DATA_W-1:0] wr_vj_i,
  input  logic [TAG_W-1:0]  wr_qj_i,
  input  logic [DATA_W-1:0] wr_vk_i,
  input  logic [TAG_W-1:0]  wr_qk_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  input  logic              disp_i,
  input  logic              free_i,
  output logic              valid_o,
  output logic              ready_o,
  output logic [2:0]        op_o,
  output logic [DATA_W-1:0] vj_o,
  output logic [DATA_W-1:0] vk_o
);

  localparam logic [TAG_W-1:0] SEM_TAG = TAG_W'(TAG_NONE);

  logic              valid_q, valid_d;
  logic              inflight_q, inflight_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;

  logic hit_j, hit_k, byp_j, byp_k;

  assign hit_j = cdb_valid_i && (qj_q != SEM_TAG) && (cdb_tag_i == qj_q);
  assign hit_k = cdb_valid_i && (qk_q != SEM_TAG) && (cdb_tag_i == qk_q);
  assign byp_j = cdb_valid_i && (wr_qj_i != SEM_TAG) && (cdb_tag_i == wr_qj_i);
  assign byp_k = cdb_valid_i && (wr_qk_i != SEM_TAG) && (cdb_tag_i == wr_qk_i);

  // Next-state: issue write wins (entry is free then), otherwise snoop/dispatch/free.
  always_comb begin
    valid_d    = valid_q;
    inflight_d = inflight_q;
    op_d       = op_q;
    vj_d       = vj_q;
    qj_d       = qj_q;
    vk_d       = vk_q;
    qk_d       = qk_q;
    if (wr_i) begin
      valid_d    = 1'b1;
      inflight_d = 1'b0;
      op_d       = wr_op_i;
      vj_d       = byp_j ? cdb_data_i : wr_vj_i;
      qj_d       = byp_j ? SEM_TAG : wr_qj_i;
      vk_d       = byp_k ? cdb_data_i : wr_vk_i;
      qk_d       = byp_k ? SEM_TAG : wr_qk_i;
    end else if (valid_q) begin
      if (hit_j) begin
        vj_d = cdb_data_i;
        qj_d = SEM_TAG;
      end
      if (hit_k) begin
        vk_d = cdb_data_i;
        qk_d = SEM_TAG;
      end
      if (disp_i) inflight_d = 1'b1;
      if (free_i) begin
        valid_d    = 1'b0;
        inflight_d = 1'b0;
      end
    end
  end

  // Entry registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      valid_q    <= 1'b0;
      inflight_q <= 1'b0;
      op_q       <= '0;
      vj_q       <= '0;
      qj_q       <= '0;
      vk_q       <= '0;
      qk_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      op_q       <= op_d;
      vj_q       <= vj_d;
      qj_q       <= qj_d;
      vk_q       <= vk_d;
      qk_q       <= qk_d;
    end
  end

  assign valid_o = valid_q;
  assign ready_o = valid_q && (qj_q == SEM_TAG) && (qk_q == SEM_TAG) && !inflight_q;
  assign op_o    = op_q;
  assign vj_o    = vj_q;
  assign vk_o    = vk_q;

endmodule

// File: rtl/estacao_reserva_ua.sv
// Reservation station for one UA: allocates entries on issue, dispatches
// the lowest ready entry, waits for the UA result and broadcasts it.
module estacao_reserva_ua
  import tomasulo_pkg::*;
#(
  parameter int N_ENTRADAS = 3,
  parameter int ID_BASE    = 1,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              issue_valid,
  input  logic [2:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_id,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              ua_start,
  output logic [TAG_W-1:0]  ua_id,
  output logic [2:0]        ua_op,
  output logic [DATA_W-1:0] ua_dado1,
  output logic [DATA_W-1:0] ua_dado2,
  input  logic              ua_busy,
  input  logic              ua_confirmacao,
  input  logic [18:0]       ua_resultado,
  output logic              bc_req,
  output logic [TAG_W-1:0]  bc_tag,
  output logic [DATA_W-1:0] bc_data,
  input  logic              bc_grant
);

  logic [N_ENTRADAS-1:0] ent_valid, ent_ready, livre, livre_oh, pronta_oh;
  logic [N_ENTRADAS-1:0] ent_wr, ent_disp, ent_free;
  logic [2:0]            ent_op [N_ENTRADAS];
  logic [DATA_W-1:0]     ent_vj [N_ENTRADAS];
  logic [DATA_W-1:0]     ent_vk [N_ENTRADAS];

  logic [1:0]            state_q, state_d;
  logic [TAG_W-1:0]      ua_id_q, ua_id_d;
  logic [2:0]            ua_op_q, ua_op_d;
  logic [DATA_W-1:0]     ua_dado1_q, ua_dado1_d, ua_dado2_q, ua_dado2_d;
  logic [TAG_W-1:0]      bc_tag_q, bc_tag_d;
  logic [DATA_W-1:0]     bc_data_q, bc_data_d;
  logic [N_ENTRADAS-1:0] disp_oh_q, disp_oh_d;

  logic                  issue_aceito, despacha;
  logic [TAG_W-1:0]      sel_id;
  logic [2:0]            sel_op;
  logic [DATA_W-1:0]     sel_vj, sel_vk;
  logic                  unused_res;

  assign unused_res = ^ua_resultado[18:16];

  // Lowest-index one-hot picks for allocation and dispatch.
  assign livre     = ~ent_valid;
  assign livre_oh  = livre & (~livre + N_ENTRADAS'(1));
  assign pronta_oh = ent_ready & (~ent_ready + N_ENTRADAS'(1));

  assign issue_ready  = |livre;
  assign issue_aceito = issue_valid && issue_ready && op_suportado(issue_op);
  assign ent_wr       = issue_aceito ? livre_oh : '0;
  assign despacha     = (state_q == ST_IDLE) && (|ent_ready) && !ua_busy;
  assign ent_disp     = despacha ? pronta_oh : '0;
  // The freed entry stays occupied through the grant cycle itself.
  assign ent_free     = ((state_q == ST_BCAST) && bc_grant) ? disp_oh_q : '0;

  // One-hot selects to ID and operand values.
  always_comb begin
    issue_id = '0;
    sel_id   = '0;
    sel_op   = '0;
    sel_vj   = '0;
    sel_vk   = '0;
    for (int k = 0; k < N_ENTRADAS; k++) begin
      if (livre_oh[k]) issue_id = issue_id | TAG_W'(ID_BASE + k);
      if (pronta_oh[k]) begin
        sel_id = sel_id | TAG_W'(ID_BASE + k);
        sel_op = sel_op | ent_op[k];
        sel_vj = sel_vj | ent_vj[k];
        sel_vk = sel_vk | ent_vk[k];
      end
    end
  end

  for (genvar k = 0; k < N_ENTRADAS; k++) begin : g_ent
    estacao_entrada #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W)
    ) u_ent (
      .CLK        (CLK),
      .CLR        (CLR),
      .wr_i       (ent_wr[k]),
      .wr_op_i    (issue_op),
      .wr_vj_i    (issue_vj),
      .wr_qj_i    (issue_qj),
      .wr_vk_i    (issue_vk),
      .wr_qk_i    (issue_qk),
      .cdb_valid_i(cdb_valid),
      .cdb_tag_i  (cdb_tag),
      .cdb_data_i (cdb_data),
      .disp_i     (ent_disp[k]),
      .free_i     (ent_free[k]),
      .valid_o    (ent_valid[k]),
      .ready_o    (ent_ready[k]),
      .op_o       (ent_op[k]),
      .vj_o       (ent_vj[k]),
      .vk_o       (ent_vk[k])
    );
  end

  // Dispatch FSM next-state and output-register loads.
  always_comb begin
    state_d    = state_q;
    ua_id_d    = ua_id_q;
    ua_op_d    = ua_op_q;
    ua_dado1_d = ua_dado1_q;
    ua_dado2_d = ua_dado2_q;
    bc_tag_d   = bc_tag_q;
    bc_data_d  = bc_data_q;
    disp_oh_d  = disp_oh_q;
    case (state_q)
      ST_IDLE: begin
        if (despacha) begin
          ua_id_d    = sel_id;
          ua_op_d    = sel_op;
          ua_dado1_d = sel_vj;
          ua_dado2_d = sel_vk;
          disp_oh_d  = pronta_oh;
          state_d    = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ua_confirmacao && !ua_busy) begin
          bc_data_d = DATA_W'(ua_resultado[15:0]);
          bc_tag_d  = ua_id_q;
          state_d   = ST_BCAST;
        end
      end
      ST_BCAST: begin
        if (bc_grant) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers; CLR abandons any in-flight operation.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      ua_id_q    <= '0;
      ua_op_q    <= '0;
      ua_dado1_q <= '0;
      ua_dado2_q <= '0;
      bc_tag_q   <= '0;
      bc_data_q  <= '0;
      disp_oh_q  <= '0;
    end else begin
      state_q    <= state_d;
      ua_id_q    <= ua_id_d;
      ua_op_q    <= ua_op_d;
      ua_dado1_q <= ua_dado1_d;
      ua_dado2_q <= ua_dado2_d;
      bc_tag_q   <= bc_tag_d;
      bc_data_q  <= bc_data_d;
      disp_oh_q  <= disp_oh_d;
    end
  end

  assign ua_start = (state_q == ST_START);
  assign bc_req   = (state_q == ST_BCAST);
  assign ua_id    = ua_id_q;
  assign ua_op    = ua_op_q;
  assign ua_dado1 = ua_dado1_q;
  assign ua_dado2 = ua_dado2_q;
  assign bc_tag   = bc_tag_q;
  assign bc_data  = bc_data_q;

endmodule

// File: tb/tb_estacao_reserva_ua.sv
// Bench for estacao_reserva_ua: a 3-cycle UA model, a CDB that returns
// granted broadcasts, and a scoreboard of expected dispatches/broadcasts.
module tb_estacao_reserva_ua;

  localparam int DW = 16;
  localparam int TW = 3;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] SUB = 3'b010;
  localparam logic [2:0] LD  = 3'b011;

  logic          CLK, CLR;
  logic          issue_valid;
  logic [2:0]    issue_op;
  logic [DW-1:0] issue_vj, issue_vk;
  logic [TW-1:0] issue_qj, issue_qk;
  logic          issue_ready;
  logic [TW-1:0] issue_id;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          ua_start;
  logic [TW-1:0] ua_id;
  logic [2:0]    ua_op;
  logic [DW-1:0] ua_dado1, ua_dado2;
  logic          ua_busy, ua_confirmacao;
  logic [18:0]   ua_resultado;
  logic          bc_req;
  logic [TW-1:0] bc_tag;
  logic [DW-1:0] bc_data;
  logic          bc_grant;

  logic          ext_valid;
  logic [TW-1:0] ext_tag;
  logic [DW-1:0] ext_data;

  int checks = 0;
  int errors = 0;
  int start_count = 0;
  int grant_hold = 0;
  int hold_cnt = 0;

  logic [TW-1:0]    exp_disp[$];
  logic [TW+DW-1:0] exp_bc[$];

  estacao_reserva_ua dut (
    .CLK(CLK), .CLR(CLR),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_ready(issue_ready), .issue_id(issue_id),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ua_start(ua_start), .ua_id(ua_id), .ua_op(ua_op),
    .ua_dado1(ua_dado1), .ua_dado2(ua_dado2),
    .ua_busy(ua_busy), .ua_confirmacao(ua_confirmacao), .ua_resultado(ua_resultado),
    .bc_req(bc_req), .bc_tag(bc_tag), .bc_data(bc_data), .bc_grant(bc_grant)
  );

  assign cdb_valid = ext_valid | (bc_req & bc_grant);
  assign cdb_tag   = (bc_req & bc_grant) ? bc_tag  : ext_tag;
  assign cdb_data  = (bc_req & bc_grant) ? bc_data : ext_data;

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // UA model: start at edge E, result valid after E+2, garbage before.
  logic [1:0]    ua_cnt;
  logic [DW-1:0] ua_pend;
  always @(posedge CLK) begin
    if (CLR) begin
      ua_busy <= 0; ua_confirmacao <= 0; ua_resultado <= '0; ua_cnt <= 0; ua_pend <= '0;
    end else if (ua_start && !ua_busy) begin
      ua_busy <= 1; ua_confirmacao <= 0; ua_cnt <= 2; ua_resultado <= 19'h7FFFF;
      ua_pend <= (ua_op == SUB) ? ua_dado1 - ua_dado2 : ua_dado1 + ua_dado2;
    end else if (ua_cnt != 0) begin
      ua_cnt <= ua_cnt - 1;
      if (ua_cnt == 1) begin
        ua_busy <= 0; ua_confirmacao <= 1; ua_resultado <= {3'b101, ua_pend};
      end
    end
  end

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
    end
  endtask

  // Grant driver: hold bc_req for grant_hold cycles, then grant one cycle.
  initial begin
    bc_grant = 0;
    forever begin
      @(negedge CLK);
      if (bc_req) begin
        if (hold_cnt >= grant_hold) bc_grant = 1;
        else hold_cnt++;
      end
      @(posedge CLK); #1;
      if (bc_grant || !bc_req) begin
        bc_grant = 0;
        hold_cnt = 0;
      end
    end
  end

  // Monitor: pops expectations on each dispatch and each new broadcast.
  initial begin
    logic prev_req, prev_start;
    logic [TW-1:0] lat_tag, e_id;
    logic [DW-1:0] lat_data;
    logic [TW+DW-1:0] e_bc;
    prev_req = 0; prev_start = 0; lat_tag = '0; lat_data = '0;
    forever begin
      @(negedge CLK);
      if (ua_start) begin
        start_count++;
        chk("ua_start_single_cycle", prev_start, 0);
        chk("disp_expected", exp_disp.size() != 0, 1);
        if (exp_disp.size() != 0) begin
          e_id = exp_disp.pop_front();
          chk("ua_id_order", ua_id, e_id);
        end
      end
      if (bc_req && !prev_req) begin
        chk("bc_expected", exp_bc.size() != 0, 1);
        if (exp_bc.size() != 0) begin
          e_bc = exp_bc.pop_front();
          chk("bc_tag", bc_tag, e_bc[TW+DW-1:DW]);
          chk("bc_data", bc_data, e_bc[DW-1:0]);
        end
        lat_tag = bc_tag;
        lat_data = bc_data;
      end else if (bc_req) begin
        chk("bc_tag_stable", bc_tag, lat_tag);
        chk("bc_data_stable", bc_data, lat_data);
      end
      prev_req = bc_req;
      prev_start = ua_start;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Called just after a rising edge; presents an issue for one cycle.
  task automatic do_issue(input string nome, input logic [2:0] op,
                          input logic [DW-1:0] vj, input logic [TW-1:0] qj,
                          input logic [DW-1:0] vk, input logic [TW-1:0] qk,
                          input logic exp_rdy, input logic chk_id, input logic [TW-1:0] exp_id);
    issue_valid = 1; issue_op = op;
    issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
    @(negedge CLK);
    chk({nome, "_ready"}, issue_ready, exp_rdy);
    if (chk_id) chk({nome, "_id"}, issue_id, exp_id);
    tick();
    issue_valid = 0;
  endtask

  task automatic cdb_pulse(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    ext_valid = 1; ext_tag = tag; ext_data = data;
    tick();
    ext_valid = 0;
  endtask

  task automatic drain(input string nome, input int budget);
    int n;
    n = 0;
    while ((exp_bc.size() != 0 || exp_disp.size() != 0 || bc_req) && n < budget) begin
      tick();
      n++;
    end
    chk({nome, "_drained"}, n < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n;
    CLR = 1; issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
    issue_qj = 0; issue_qk = 0; ext_valid = 0; ext_tag = 0; ext_data = 0;
    repeat (3) @(posedge CLK);
    #1 CLR = 0;

    // Reset state
    @(negedge CLK);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_ua_start", ua_start, 0);
    chk("rst_bc_req", bc_req, 0);
    chk("rst_ua_id", ua_id, 0);
    chk("rst_ua_op", ua_op, 0);
    chk("rst_bc_tag", bc_tag, 0);
    chk("rst_bc_data", bc_data, 0);
    tick();

    // Simple add 5+7
    grant_hold = 0;
    s0 = start_count;
    exp_disp.push_back(3'd1); exp_bc.push_back({3'd1, 16'd12});
    do_issue("add", ADD, 16'd5, 3'd0, 16'd7, 3'd0, 1, 1, 3'd1);
    @(negedge CLK);
    chk("add_no_start_yet", ua_start, 0);
    @(negedge CLK);
    chk("add_start", ua_start, 1);
    chk("add_ua_op", ua_op, ADD);
    chk("add_dado1", ua_dado1, 5);
    chk("add_dado2", ua_dado2, 7);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("add_bc_req_low", bc_req, 0);
    end
    @(negedge CLK);
    chk("add_bc_req_high", bc_req, 1);
    drain("add", 40);
    chk("add_one_start", start_count - s0, 1);

    // Sub waiting on tag 5
    s0 = start_count;
    exp_disp.push_back(3'd1); exp_bc.push_back({3'd1, 16'd17});
    do_issue("sub", SUB, 16'd99, 3'd5, 16'd3, 3'd0, 1, 1, 3'd1);
    tick(); tick();
    chk("sub_no_start_before_cdb", start_count - s0, 0);
    cdb_pulse(3'd5, 16'd20);
    drain("sub", 40);

    // Same-cycle bypass on Qk
    exp_disp.push_back(3'd1); exp_bc.push_back({3'd1, 16'd11});
    ext_valid = 1; ext_tag = 3'd4; ext_data = 16'd9;
    do_issue("byp", ADD, 16'd2, 3'd0, 16'd0, 3'd4, 1, 1, 3'd1);
    ext_valid = 0;
    @(posedge CLK);
    @(negedge CLK);
    chk("byp_no_wait_start", ua_start, 1);
    drain("byp", 40);

    // Fill all entries on tag 6, held grants
    grant_hold = 4;
    exp_disp.push_back(3'd1); exp_disp.push_back(3'd2); exp_disp.push_back(3'd3);
    exp_bc.push_back({3'd1, 16'd101});
    exp_bc.push_back({3'd2, 16'd70});
    exp_bc.push_back({3'd3, 16'd104});
    do_issue("fill1", ADD, 16'd0, 3'd6, 16'd1, 3'd0, 1, 1, 3'd1);
    do_issue("fill2", SUB, 16'd0, 3'd6, 16'd30, 3'd0, 1, 1, 3'd2);
    do_issue("fill3", LD, 16'd0, 3'd6, 16'd4, 3'd0, 1, 1, 3'd3);
    do_issue("fill4", ADD, 16'd1, 3'd0, 16'd1, 3'd0, 0, 0, 3'd0);
    tick();
    cdb_pulse(3'd6, 16'd100);
    n = 0;
    while (n < 40) begin
      @(negedge CLK); #1;
      if (bc_grant) break;
      n++;
    end
    chk("full_grant_seen", n < 40, 1);
    chk("full_on_grant_cycle", issue_ready, 0);
    tick();
    chk("free_after_grant", issue_ready, 1);
    drain("fill", 120);

    // Unsupported ops are dropped
    grant_hold = 0;
    s0 = start_count;
    do_issue("bad111", 3'b111, 16'd1, 3'd0, 16'd1, 3'd0, 1, 0, 3'd0);
    do_issue("bad000", 3'b000, 16'd1, 3'd0, 16'd1, 3'd0, 1, 0, 3'd0);
    repeat (6) tick();
    chk("bad_op_no_start", start_count - s0, 0);

    // Dependency chain through own broadcast
    exp_disp.push_back(3'd1); exp_disp.push_back(3'd2);
    exp_bc.push_back({3'd1, 16'd7}); exp_bc.push_back({3'd2, 16'd17});
    do_issue("chain1", ADD, 16'd3, 3'd0, 16'd4, 3'd0, 1, 1, 3'd1);
    do_issue("chain2", ADD, 16'd0, 3'd1, 16'd10, 3'd0, 1, 1, 3'd2);
    drain("chain", 60);

    // CLR during WAIT
    exp_disp.push_back(3'd1);
    do_issue("clr", ADD, 16'd1, 3'd0, 16'd1, 3'd0, 1, 1, 3'd1);
    n = 0;
    while (n < 20) begin
      @(negedge CLK);
      if (ua_start) break;
      n++;
    end
    chk("clr_start_seen", n < 20, 1);
    tick();
    CLR = 1;
    tick();
    CLR = 0;
    @(negedge CLK);
    chk("clr_ua_start", ua_start, 0);
    chk("clr_bc_req", bc_req, 0);
    chk("clr_issue_ready", issue_ready, 1);
    repeat (6) tick();
    chk("clr_no_bc", bc_req, 0);
    exp_disp.push_back(3'd1); exp_bc.push_back({3'd1, 16'd4});
    do_issue("post_clr", ADD, 16'd2, 3'd0, 16'd2, 3'd0, 1, 1, 3'd1);
    drain("post_clr", 40);

    repeat (4) tick();
    chk("end_disp_queue", exp_disp.size(), 0);
    chk("end_bc_queue", exp_bc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
